// File: rtl/io_timer_pkg.sv
// Shared defines for the I/O timer: register offsets, CTRL field positions,
// reset values and the CTRL word/struct conversions.
package io_timer_pkg;

  localparam logic [11:0] OFF_CTRL   = 12'h000;
  localparam logic [11:0] OFF_PERIOD = 12'h004;
  localparam logic [11:0] OFF_COUNT  = 12'h008;
  localparam logic [11:0] OFF_STATUS = 12'h00C;

  localparam int CTRL_EN        = 0;
  localparam int CTRL_ONESHOT   = 1;
  localparam int CTRL_IE        = 2;
  localparam int CTRL_PRESC_LSB = 8;
  localparam int CTRL_PRESC_MSB = 15;
  localparam int STATUS_EXP     = 0;

  localparam logic [31:0] PERIOD_RST = 32'hFFFF_FFFF;

  typedef struct packed {
    logic [7:0] presc;
    logic       ie;
    logic       oneshot;
    logic       en;
  } ctrl_t;

  localparam ctrl_t CTRL_RST = '0;

  function automatic ctrl_t ctrl_from_word(input logic [31:0] w);
    ctrl_t c;
    c.en      = w[CTRL_EN];
    c.oneshot = w[CTRL_ONESHOT];
    c.ie      = w[CTRL_IE];
    c.presc   = w[CTRL_PRESC_MSB:CTRL_PRESC_LSB];
    return c;
  endfunction

  // Unimplemented CTRL bits always read back as zero.
  function automatic logic [31:0] ctrl_to_word(input ctrl_t c);
    logic [31:0] w;
    w                                = '0;
    w[CTRL_EN]                       = c.en;
    w[CTRL_ONESHOT]                  = c.oneshot;
    w[CTRL_IE]                       = c.ie;
    w[CTRL_PRESC_MSB:CTRL_PRESC_LSB] = c.presc;
    return w;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// Clock prescaler: counts 0..presc while enabled and issues one tick on the
// cycle it sits at presc, so ticks arrive every presc+1 cycles.
module timer_prescaler
  import io_timer_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en_i,
  input  logic       clr_i,
  input  logic [7:0] presc_i,
  output logic       tick_o
);

  logic [7:0] cnt_q, cnt_d;

  assign tick_o = en_i & (cnt_q == presc_i);

  // Clear wins over counting; a disabled prescaler holds its position.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)     cnt_d = '0;
    else if (en_i) cnt_d = tick_o ? 8'd0 : cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/io_timer.sv
// Memory-mapped interval timer: CTRL/PERIOD/COUNT/STATUS word registers,
// prescaled up-counter with period-match expiry and a level interrupt.
module io_timer
  import io_timer_pkg::*;
#(
  parameter logic [11:0] BASE = 12'h020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] addr,
  input  logic        wen,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  ctrl_t       ctrl_q, ctrl_d, ctrl_wr;
  logic [31:0] period_q, period_d;
  logic [31:0] count_q, count_d;
  logic        exp_q, exp_d;

  logic sel_ctrl, sel_period, sel_count, sel_status;
  logic wr_ctrl, wr_period, wr_count, wr_status;
  logic tick, psc_clr, at_period, expire;

  assign sel_ctrl   = (addr == 12'(BASE + OFF_CTRL));
  assign sel_period = (addr == 12'(BASE + OFF_PERIOD));
  assign sel_count  = (addr == 12'(BASE + OFF_COUNT));
  assign sel_status = (addr == 12'(BASE + OFF_STATUS));

  assign wr_ctrl   = wen & sel_ctrl;
  assign wr_period = wen & sel_period;
  assign wr_count  = wen & sel_count;
  assign wr_status = wen & sel_status;

  assign ctrl_wr = ctrl_from_word(wdata);

  // Restart the prescale phase on a COUNT load or on an EN rising write.
  assign psc_clr = wr_count | (wr_ctrl & ~ctrl_q.en & ctrl_wr.en);

  timer_prescaler u_psc (
    .clk     (clk),
    .rst     (rst),
    .en_i    (ctrl_q.en),
    .clr_i   (psc_clr),
    .presc_i (ctrl_q.presc),
    .tick_o  (tick)
  );

  // A COUNT load swallows a coincident tick, including its expiry.
  assign at_period = (count_q == period_q);
  assign expire    = tick & ~wr_count & at_period;

  always_comb begin
    ctrl_d   = ctrl_q;
    period_d = period_q;
    count_d  = count_q;

    if (wr_ctrl)                            ctrl_d    = ctrl_wr;
    else if (expire && ctrl_q.oneshot)      ctrl_d.en = 1'b0;

    if (wr_period) period_d = wdata;

    // Counter only compares for equality, so a PERIOD below COUNT wraps first.
    if (wr_count)  count_d = wdata;
    else if (tick) count_d = at_period ? 32'd0 : count_q + 32'd1;

    // W1C; a same-cycle expiry keeps EXP set.
    exp_d = expire | (exp_q & ~(wr_status & wdata[STATUS_EXP]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q   <= CTRL_RST;
      period_q <= PERIOD_RST;
      count_q  <= '0;
      exp_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      period_q <= period_d;
      count_q  <= count_d;
      exp_q    <= exp_d;
    end
  end

  always_comb begin
    rdata = '0;
    if (sel_ctrl)   rdata = ctrl_to_word(ctrl_q);
    if (sel_period) rdata = period_q;
    if (sel_count)  rdata = count_q;
    if (sel_status) rdata[STATUS_EXP] = exp_q;
  end

  assign irq = exp_q & ctrl_q.ie;

endmodule
